// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit ADD/SUB/ADDC/SUBB with valid/ready handshake; carry chain split over STAGES register stages.
// Status flags (carry/ovf/zero/neg) exist only with PIPE_ADDER_FLAGS_EN defined; otherwise the flag ports are tied to 0.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } stg_t;

  logic                     adv;
  logic [STAGES-1:0]        v_q, v_d;
  stg_t                     in_stg;
  stg_t [STAGES-1:0]        stg_q, stg_d;
  // chain[k] feeds stage k; chain[STAGES] is the last register, i.e. the output.
  stg_t [STAGES:0]          chain;
  logic                     unused_bits;

  assign adv       = !v_q[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[L];
  assign out_sum   = chain[STAGES].sum;
  assign out_tag   = chain[STAGES].tag;

  always_comb begin
    in_stg     = '0;
    in_stg.a   = in_a;
    in_stg.bx  = in_op[0] ? ~in_b : in_b;
    in_stg.c   = in_op[1] ? in_cin : in_op[0];
    in_stg.op  = in_op;
    in_stg.tag = in_tag;
  end

  always_comb begin
    chain    = '0;
    chain[0] = in_stg;
    for (int k = 0; k < STAGES; k++) chain[k+1] = stg_q[k];
  end

  always_comb begin
    v_d = v_q;
    if (adv) begin
      v_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) v_d[k] = v_q[k-1];
    end
  end

  // Each stage adds its own S-bit slice with the carry handed over by the previous register.
  always_comb begin
    logic [S:0] part;
    part  = '0;
    stg_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, chain[k].a[k*S +: S]} + {1'b0, chain[k].bx[k*S +: S]}
           + {{S{1'b0}}, chain[k].c};
      stg_d[k]              = chain[k];
      stg_d[k].sum[k*S +: S] = part[S-1:0];
      stg_d[k].c            = part[S];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      stg_q <= '0;
    end else if (adv) begin
      v_q   <= v_d;
      stg_q <= stg_d;
    end
  end

`ifdef PIPE_ADDER_FLAGS_EN
  logic ovf_q, ovf_d, zero_q, zero_d;

  // Overflow uses the MSBs of a and b' as they sit in the final stage's input register.
  always_comb begin
    ovf_d  = (chain[L].a[WIDTH-1] == chain[L].bx[WIDTH-1]) &&
             (stg_d[L].sum[WIDTH-1] != chain[L].a[WIDTH-1]);
    zero_d = (stg_d[L].sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_carry = chain[STAGES].c;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = chain[STAGES].sum[WIDTH-1];
`else
  assign out_carry = 1'b0;
  assign out_ovf   = 1'b0;
  assign out_zero  = 1'b0;
  assign out_neg   = 1'b0;
`endif

  assign unused_bits = ^{chain[STAGES].a, chain[STAGES].bx, chain[STAGES].op, chain[STAGES].c};

endmodule
